// File: rtl/neopixel_frame_scheduler.sv
// neopixel_frame_scheduler
//   Sequences whole frames into the neopixel driver's pixel-write port.
//   Two pattern sources share the strip through round-robin arbitration.
//   A grant always covers one whole frame. Frame starts are paced by a
//   free-running frame timer. Each written pixel is held for HOLD_CYCLES
//   clocks so the driver can take it.
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   req[1:0]     : source i wants the next frame
//   grant[1:0]   : one-hot owner of the current frame, 0 when idle
//   pix_req      : one-cycle pulse asking the owner for pix_idx's color
//   pix_idx      : pixel index being fetched (NUM_LEDS-1 down to 0)
//   pix_valid    : pix_color is valid (taken only while fetching)
//   pix_color    : GRB color {G,R,B}
//   color, address, color_clock : driver write port
//   frame_done   : one-cycle pulse after the last pixel has been held
//   fsm_state    : current FSM state (IDLE=0, ARB=1, FETCH=2, HOLD=3)
//
// Pixel handshake: pix_req pulses on the first FETCH cycle only. The owner
// answers with pix_valid/pix_color in that cycle or any later one; the
// color is taken on the first clock edge in FETCH where pix_valid=1.
// pix_valid outside FETCH is ignored. There is no fetch timeout.
module neopixel_frame_scheduler #(
  parameter int NUM_LEDS     = 150,
  parameter int HOLD_CYCLES  = 32,
  parameter int FRAME_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  output logic [1:0]  grant,
  output logic        pix_req,
  output logic [15:0] pix_idx,
  input  logic        pix_valid,
  input  logic [23:0] pix_color,
  output logic [23:0] color,
  output logic [15:0] address,
  output logic        color_clock,
  output logic        frame_done,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_FETCH = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam int FW = $clog2(FRAME_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

  state_t        state;
  state_t        state_nx;
  logic [FW-1:0] frame_cnt;
  logic [HW-1:0] hold_cnt;
  logic          rr_ptr;
  logic          tick;

  // decoded strobes from the output process
  logic          win_idx;
  logic [1:0]    arb_win;
  logic          arb_take;
  logic          accept;
  logic          hold_end;
  logic          last_px;
  logic          enter_fetch;

  assign fsm_state = state;

  // Frame timer: free-running; ticks that land outside IDLE are simply lost.
  assign tick = (frame_cnt == FRAME_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (tick) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (tick && req != 2'b00) state_nx = S_ARB;
      // a request withdrawn during the ARB cycle leaves nothing to grant
      S_ARB:   state_nx = (req != 2'b00) ? S_FETCH : S_IDLE;
      S_FETCH: if (pix_valid) state_nx = S_HOLD;
      S_HOLD:  if (hold_cnt == HOLD_LAST) state_nx = (pix_idx == 16'd0) ? S_IDLE : S_FETCH;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    win_idx     = req[rr_ptr] ? rr_ptr : ~rr_ptr;
    arb_win     = 2'b00;
    arb_take    = 1'b0;
    accept      = 1'b0;
    hold_end    = 1'b0;
    last_px     = (pix_idx == 16'd0);
    enter_fetch = (state_nx == S_FETCH) && (state != S_FETCH);
    case (state)
      S_ARB: begin
        arb_take = (req != 2'b00);
        arb_win  = arb_take ? (2'b01 << win_idx) : 2'b00;
      end
      S_FETCH: accept   = pix_valid;
      S_HOLD:  hold_end = (hold_cnt == HOLD_LAST);
      default: ;
    endcase
  end

  // Datapath: grant, pixel index, driver port, hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= 2'b00;
      rr_ptr      <= 1'b0;
      pix_idx     <= 16'd0;
      pix_req     <= 1'b0;
      color       <= 24'd0;
      address     <= 16'(NUM_LEDS);
      color_clock <= 1'b0;
      frame_done  <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      pix_req    <= enter_fetch;
      frame_done <= hold_end && last_px;

      if (arb_take) begin
        grant   <= arb_win;
        rr_ptr  <= ~win_idx;
        pix_idx <= 16'(NUM_LEDS - 1);
      end

      // all driver inputs change together on the toggle edge
      if (accept) begin
        color       <= pix_color;
        address     <= pix_idx;
        color_clock <= ~color_clock;
      end

      if (state == S_HOLD) begin
        hold_cnt <= hold_end ? '0 : hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end

      if (hold_end) begin
        if (last_px) begin
          grant <= 2'b00;
        end else begin
          pix_idx <= pix_idx - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_neopixel_frame_scheduler.sv
// Testbench for neopixel_frame_scheduler (NUM_LEDS=4, HOLD_CYCLES=4, FRAME_CYCLES=64).
// A cycle-level model predicts, from tick times, the round-robin rule and the
// source response delays, when each grant, pix_req, toggle and frame_done
// must appear and what the driver port must hold; it is compared every cycle.
// Directed tests add literal expectations on the logged writes and grants.
module tb_neopixel_frame_scheduler;

  localparam int N  = 4;
  localparam int H  = 4;
  localparam int FC = 64;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  grant;
  logic        pix_req;
  logic [15:0] pix_idx;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_color = 24'd0;
  logic [23:0] color;
  logic [15:0] address;
  logic        color_clock;
  logic        frame_done;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  neopixel_frame_scheduler #(
    .NUM_LEDS(N), .HOLD_CYCLES(H), .FRAME_CYCLES(FC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
    .pix_req(pix_req), .pix_idx(pix_idx), .pix_valid(pix_valid),
    .pix_color(pix_color), .color(color), .address(address),
    .color_clock(color_clock), .frame_done(frame_done), .fsm_state(fsm_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] color_fn(input logic src, input int idx);
    logic [23:0] c;
    c = 24'(idx) * 24'h010101;
    if (src) c = c ^ 24'hA00000;
    return c;
  endfunction

  int delay_tab[N];
  logic [39:0] tog_log[$];
  int          tog_cyc[$];
  logic [1:0]  grant_log[$];
  int          preq_cnt = 0;
  int          done_cnt = 0;

  // ---------------- pattern source driver ----------------
  always begin
    @(negedge clk);
    if (rst_n && pix_req) begin
      automatic int   idx = int'(pix_idx);
      automatic logic src = grant[1];
      repeat (delay_tab[idx]) @(negedge clk);
      pix_color = color_fn(src, idx);
      pix_valid = 1'b1;
      @(posedge clk);
      #1 pix_valid = 1'b0;
    end
  end

  // ---------------- behavioural model + compare ----------------
  int          cyc = 0;
  int          mcnt = 0;
  bit          was_rst = 1'b1;
  bit          m_busy = 1'b0;
  bit          m_ptr = 1'b0;
  bit          m_owner = 1'b0;
  logic [1:0]  m_grant = 2'b00;
  int          m_idx = 0;
  logic [23:0] m_color = 24'd0;
  logic [15:0] m_addr = 16'(N);
  logic        m_cc = 1'b0;
  int          grant_cyc = -1, req_cyc = -1, tog_exp = -1, done_cyc = -1;
  logic        prev_cc = 1'b0;
  logic [1:0]  prev_grant = 2'b00;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      was_rst = 1'b1; mcnt = 0; m_busy = 1'b0; m_ptr = 1'b0;
      m_grant = 2'b00; m_color = 24'd0; m_addr = 16'(N); m_cc = 1'b0;
      grant_cyc = -1; req_cyc = -1; tog_exp = -1; done_cyc = -1;
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_pix_req", 64'(pix_req), 64'd0);
      chk("rst_pix_idx", 64'(pix_idx), 64'd0);
      chk("rst_color", 64'(color), 64'd0);
      chk("rst_address", 64'(address), 64'(N));
      chk("rst_color_clock", 64'(color_clock), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
    end else begin
      if (was_rst) begin was_rst = 1'b0; mcnt = 0; end
      else mcnt = (mcnt + 1) % FC;

      if (cyc == grant_cyc) begin
        m_grant = m_owner ? 2'b10 : 2'b01;
        m_idx   = N - 1;
        req_cyc = cyc;
      end
      if (cyc == req_cyc) tog_exp = cyc + delay_tab[m_idx] + 1;
      if (cyc == req_cyc) chk("pix_idx", 64'(pix_idx), 64'(m_idx));
      if (cyc == tog_exp) begin
        m_color = color_fn(m_owner, m_idx);
        m_addr  = 16'(m_idx);
        m_cc    = ~m_cc;
        if (m_idx > 0) begin req_cyc = cyc + H; m_idx--; end
        else done_cyc = cyc + H;
      end
      if (cyc == done_cyc) begin m_grant = 2'b00; m_busy = 1'b0; end

      chk("grant", 64'(grant), 64'(m_grant));
      chk("pix_req", 64'(pix_req), 64'(cyc == req_cyc));
      chk("color_clock", 64'(color_clock), 64'(m_cc));
      chk("color", 64'(color), 64'(m_color));
      chk("address", 64'(address), 64'(m_addr));
      chk("frame_done", 64'(frame_done), 64'(cyc == done_cyc));

      if (color_clock !== prev_cc) begin
        tog_log.push_back({address, color});
        tog_cyc.push_back(cyc);
      end
      if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant);
      if (pix_req) preq_cnt++;
      if (frame_done) done_cnt++;

      // frame start decision on a tick seen while idle
      if (!m_busy && mcnt == FC - 1 && req != 2'b00) begin
        m_owner   = req[m_ptr] ? m_ptr : ~m_ptr;
        m_ptr     = ~m_owner;
        grant_cyc = cyc + 2;
        m_busy    = 1'b1;
      end
    end
    prev_cc    = color_clock;
    prev_grant = grant;
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic [1:0] v);
    @(posedge clk);
    #1 req = v;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    tog_log.delete();
    tog_cyc.delete();
    grant_log.delete();
    preq_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_done !== 1'b1 && k < limit);
    chk(name, 64'(frame_done), 64'd1);
  endtask

  // ---------------- directed tests ----------------
  logic [39:0] exp_w;
  int          n_before;
  int          k;

  initial begin
    for (int i = 0; i < N; i++) delay_tab[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: no requests over three ticks
    clear_logs();
    repeat (3 * FC + 5) @(negedge clk);
    chk("t1_toggles", 64'(tog_log.size()), 64'd0);
    chk("t1_pix_req", 64'(preq_cnt), 64'd0);
    chk("t1_address", 64'(address), 64'(N));
    chk("t1_grant", 64'(grant), 64'd0);

    // 2: single source, immediate answers
    clear_logs();
    set_req(2'b01);
    wait_done(2 * FC + 40, "t2_done");
    set_req(2'b00);
    repeat (3) @(negedge clk);
    chk("t2_writes", 64'(tog_log.size()), 64'd4);
    if (tog_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        exp_w = {16'(3 - i), 24'(3 - i) * 24'h010101};
        chk($sformatf("t2_write%0d", i), 64'(tog_log[i]), 64'(exp_w));
      end
      for (int i = 0; i < 3; i++)
        chk($sformatf("t2_gap%0d", i), 64'(tog_cyc[i+1] - tog_cyc[i]), 64'(H + 1));
    end
    chk("t2_done_pulses", 64'(done_cnt), 64'd1);
    chk("t2_grant_seq", 64'(grant_log.size() > 0 ? grant_log[0] : 2'b00), 64'h1);

    // 3: both sources, four frames alternate from a fresh pointer
    do_reset();
    clear_logs();
    set_req(2'b11);
    for (int f = 0; f < 4; f++) wait_done(2 * FC + 40, $sformatf("t3_done%0d", f));
    set_req(2'b00);
    chk("t3_frames", 64'(grant_log.size()), 64'd4);
    if (grant_log.size() == 4) begin
      chk("t3_grant0", 64'(grant_log[0]), 64'h1);
      chk("t3_grant1", 64'(grant_log[1]), 64'h2);
      chk("t3_grant2", 64'(grant_log[2]), 64'h1);
      chk("t3_grant3", 64'(grant_log[3]), 64'h2);
    end
    chk("t3_writes", 64'(tog_log.size()), 64'd16);

    // 4: source stalls 10 cycles on pixel 2
    clear_logs();
    delay_tab[2] = 10;
    set_req(2'b01);
    wait_done(2 * FC + 40, "t4_done");
    set_req(2'b00);
    delay_tab[2] = 0;
    chk("t4_pix_req_count", 64'(preq_cnt), 64'd4);
    chk("t4_writes", 64'(tog_log.size()), 64'd4);
    if (tog_log.size() == 4) begin
      chk("t4_gap_idx2", 64'(tog_cyc[1] - tog_cyc[0]), 64'(H + 1 + 10));
      chk("t4_write_idx2", 64'(tog_log[1]), 64'({16'd2, 24'h020202}));
    end

    // 5: request dropped mid-frame
    clear_logs();
    set_req(2'b01);
    k = 0;
    while (tog_log.size() < 2 && k < 2 * FC + 40) begin @(negedge clk); k++; end
    chk("t5_two_writes", 64'(tog_log.size() >= 2), 64'd1);
    set_req(2'b00);
    wait_done(2 * FC + 40, "t5_done");
    repeat (2 * FC) @(negedge clk);
    chk("t5_writes", 64'(tog_log.size()), 64'd4);
    chk("t5_frames", 64'(grant_log.size()), 64'd1);
    chk("t5_grant_idle", 64'(grant), 64'd0);

    // 6: reset while pixel 1 is being held
    clear_logs();
    set_req(2'b01);
    k = 0;
    while (address !== 16'd1 && k < 2 * FC + 40) begin @(negedge clk); k++; end
    chk("t6_reach_pix1", 64'(address), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_address", 64'(address), 64'(N));
    chk("t6_rst_cc", 64'(color_clock), 64'd0);
    chk("t6_rst_grant", 64'(grant), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_before = tog_log.size();
    chk("t6_writes_before", 64'(n_before), 64'd3);
    repeat (10) @(negedge clk);
    chk("t6_no_toggle_after", 64'(tog_log.size()), 64'(n_before));
    wait_done(2 * FC + 40, "t6_done");
    set_req(2'b00);
    chk("t6_new_writes", 64'(tog_log.size() - n_before), 64'd4);
    if (tog_log.size() == n_before + 4) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("t6_addr%0d", i), 64'(tog_log[n_before + i][39:24]), 64'(3 - i));
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
